// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter: state encodings,
// parity modes, default frame shape and the output payload struct.
package uart_tx_cfg_pkg;

  localparam int unsigned ST_W = 5;

  // One-hot frame states
  localparam logic [ST_W-1:0] ST_IDLE   = 5'b00001;
  localparam logic [ST_W-1:0] ST_START  = 5'b00010;
  localparam logic [ST_W-1:0] ST_DATA   = 5'b00100;
  localparam logic [ST_W-1:0] ST_PARITY = 5'b01000;
  localparam logic [ST_W-1:0] ST_STOP   = 5'b10000;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned DEF_WIDTH_WORD = 8;
  localparam int unsigned DEF_STOP       = 1;
  localparam int unsigned DEF_TICKS      = 16;
  localparam int unsigned MAX_WIDTH_WORD = 9;

  typedef struct packed {
    logic bit_tx;
    logic busy;
    logic done;
  } tx_out_t;

  // Zero-extension to the widest word leaves the parity unchanged
  function automatic logic parity_of(input logic [MAX_WIDTH_WORD-1:0] word,
                                     input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^word) : ^word;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Request/serial-line bundle between a word source and the UART transmitter.
interface uart_tx_cfg_if
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned WIDTH_WORD_TX = DEF_WIDTH_WORD
);

  logic                     i_rate;
  logic [WIDTH_WORD_TX-1:0] i_data_in;
  logic                     i_tx_start;
  logic                     o_bit_tx;
  logic                     o_tx_busy;
  logic                     o_tx_done;

  modport master (
    output i_rate, i_data_in, i_tx_start,
    input  o_bit_tx, o_tx_busy, o_tx_done
  );

  modport slave (
    input  i_rate, i_data_in, i_tx_start,
    output o_bit_tx, o_tx_busy, o_tx_done
  );

endinterface

// File: rtl/uart_tick_counter.sv
// Counts baud ticks within one serial bit and flags the tick that closes the bit.
module uart_tick_counter #(
  parameter int unsigned TICKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rate_i,
  input  logic clear_i,
  output logic bit_end_c_o
);

  localparam int unsigned CNT_W = $clog2(TICKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Held clear while idle; in-frame bit boundaries wrap it so every state starts at 0
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (rate_i) cnt_d = (cnt_q == LAST_TICK) ? '0 : cnt_q + CNT_W'(1);
  end

  assign bit_end_c_o = rate_i && !clear_i && (cnt_q == LAST_TICK);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, data bits, optional parity, stop bits,
// paced by an external baud tick; word latched when the request is accepted.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned WIDTH_WORD_TX = DEF_WIDTH_WORD,
  parameter int unsigned CANT_BIT_STOP = DEF_STOP,
  parameter int unsigned TICKS_PER_BIT = DEF_TICKS,
  parameter int unsigned PARITY_MODE   = PARITY_NONE,
  parameter bit          LSB_FIRST     = 1'b1
) (
  input logic          i_clock,
  input logic          i_reset,
  uart_tx_cfg_if.slave tx_if
);

  localparam int unsigned BIT_CNT_W = $clog2(WIDTH_WORD_TX) + 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH_WORD_TX - 1);
  localparam logic [1:0] LAST_STOP = 2'(CANT_BIT_STOP - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  if (WIDTH_WORD_TX < 5 || WIDTH_WORD_TX > 9) begin : g_bad_width
    $error("uart_tx_cfg: WIDTH_WORD_TX must be 5..9");
  end
  if (CANT_BIT_STOP < 1 || CANT_BIT_STOP > 2) begin : g_bad_stop
    $error("uart_tx_cfg: CANT_BIT_STOP must be 1..2");
  end
  if (TICKS_PER_BIT < 2 || TICKS_PER_BIT > 64) begin : g_bad_ticks
    $error("uart_tx_cfg: TICKS_PER_BIT must be 2..64");
  end
  if (PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY_MODE must be 0..2");
  end

  logic [ST_W-1:0]          state_q, state_d;
  logic [WIDTH_WORD_TX-1:0] shreg_q, shreg_d, shreg_adv;
  logic                     par_q, par_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]               stop_cnt_q, stop_cnt_d;
  tx_out_t                  out_q, out_d;
  logic                     bit_end_c;

  function automatic logic head_bit(input logic [WIDTH_WORD_TX-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH_WORD_TX-1];
  endfunction

  uart_tick_counter #(
    .TICKS_PER_BIT (TICKS_PER_BIT)
  ) u_tick (
    .clk         (i_clock),
    .rst_n       (i_reset),
    .rate_i      (tx_if.i_rate),
    .clear_i     (state_q == ST_IDLE),
    .bit_end_c_o (bit_end_c)
  );

  assign shreg_adv = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      out_q      <= '{bit_tx: 1'b1, busy: 1'b0, done: 1'b0};
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      out_q      <= out_d;
    end
  end

  // Line level for the next bit is registered together with the state change
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    out_d      = out_q;
    out_d.done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_if.i_tx_start) begin
          shreg_d      = tx_if.i_data_in;
          par_d        = parity_of(MAX_WIDTH_WORD'(tx_if.i_data_in), PARITY_MODE);
          state_d      = ST_START;
          out_d.bit_tx = 1'b0;
          out_d.busy   = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d      = ST_DATA;
          bit_cnt_d    = '0;
          out_d.bit_tx = head_bit(shreg_q);
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (HAS_PARITY) begin
              state_d      = ST_PARITY;
              out_d.bit_tx = par_q;
            end else begin
              state_d      = ST_STOP;
              stop_cnt_d   = '0;
              out_d.bit_tx = 1'b1;
            end
          end else begin
            bit_cnt_d    = bit_cnt_q + BIT_CNT_W'(1);
            shreg_d      = shreg_adv;
            out_d.bit_tx = head_bit(shreg_adv);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          state_d      = ST_STOP;
          stop_cnt_d   = '0;
          out_d.bit_tx = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d    = ST_IDLE;
            out_d.busy = 1'b0;
            out_d.done = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = '{bit_tx: 1'b1, busy: 1'b0, done: 1'b0};
      end
    endcase
  end

  assign tx_if.o_bit_tx  = out_q.bit_tx;
  assign tx_if.o_tx_busy = out_q.busy;
  assign tx_if.o_tx_done = out_q.done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations share one clock, reset and baud tick;
// a frame model built from the frame rules predicts the line level per tick count.
module tb_uart_tx_cfg;

  logic clk;
  logic rst_n;
  logic rate;
  bit   rate_fixed;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] data_in [4];
  logic       start   [4];
  logic       line_w  [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  // Configuration of each instance: width, stop bits, ticks, parity mode, lsb-first
  int cw [4] = '{8, 8, 8, 7};
  int cs [4] = '{1, 2, 2, 1};
  int ct [4] = '{16, 4, 4, 2};
  int cp [4] = '{0, 1, 2, 0};
  int cl [4] = '{1, 1, 1, 0};

  uart_tx_cfg_if #(.WIDTH_WORD_TX(8)) if0 ();
  uart_tx_cfg_if #(.WIDTH_WORD_TX(8)) if1 ();
  uart_tx_cfg_if #(.WIDTH_WORD_TX(8)) if2 ();
  uart_tx_cfg_if #(.WIDTH_WORD_TX(7)) if3 ();

  assign if0.i_rate = rate;  assign if0.i_data_in = data_in[0][7:0];  assign if0.i_tx_start = start[0];
  assign if1.i_rate = rate;  assign if1.i_data_in = data_in[1][7:0];  assign if1.i_tx_start = start[1];
  assign if2.i_rate = rate;  assign if2.i_data_in = data_in[2][7:0];  assign if2.i_tx_start = start[2];
  assign if3.i_rate = rate;  assign if3.i_data_in = data_in[3][6:0];  assign if3.i_tx_start = start[3];

  assign line_w[0] = if0.o_bit_tx;  assign busy_w[0] = if0.o_tx_busy;  assign done_w[0] = if0.o_tx_done;
  assign line_w[1] = if1.o_bit_tx;  assign busy_w[1] = if1.o_tx_busy;  assign done_w[1] = if1.o_tx_done;
  assign line_w[2] = if2.o_bit_tx;  assign busy_w[2] = if2.o_tx_busy;  assign done_w[2] = if2.o_tx_done;
  assign line_w[3] = if3.o_bit_tx;  assign busy_w[3] = if3.o_tx_busy;  assign done_w[3] = if3.o_tx_done;

  uart_tx_cfg #(.WIDTH_WORD_TX(8), .CANT_BIT_STOP(1), .TICKS_PER_BIT(16), .PARITY_MODE(0), .LSB_FIRST(1'b1))
    u_dut0 (.i_clock(clk), .i_reset(rst_n), .tx_if(if0));
  uart_tx_cfg #(.WIDTH_WORD_TX(8), .CANT_BIT_STOP(2), .TICKS_PER_BIT(4), .PARITY_MODE(1), .LSB_FIRST(1'b1))
    u_dut1 (.i_clock(clk), .i_reset(rst_n), .tx_if(if1));
  uart_tx_cfg #(.WIDTH_WORD_TX(8), .CANT_BIT_STOP(2), .TICKS_PER_BIT(4), .PARITY_MODE(2), .LSB_FIRST(1'b1))
    u_dut2 (.i_clock(clk), .i_reset(rst_n), .tx_if(if2));
  uart_tx_cfg #(.WIDTH_WORD_TX(7), .CANT_BIT_STOP(1), .TICKS_PER_BIT(2), .PARITY_MODE(0), .LSB_FIRST(1'b0))
    u_dut3 (.i_clock(clk), .i_reset(rst_n), .tx_if(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: every 4th clock in fixed mode, otherwise random one-cycle pulses
  initial begin
    int ph;
    ph   = 0;
    rate = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rate_fixed) begin
        rate = (ph == 3);
        ph   = (ph + 1) % 4;
      end else begin
        rate = ($urandom_range(0, 2) == 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [8:0] d);
    data_in[k] = d;
    start[k]   = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
  endtask

  task automatic idle_check(input int k);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("idle_line k%0d", k), 16'(line_w[k]), 16'd1);
    check($sformatf("idle_busy k%0d", k), 16'(busy_w[k]), 16'd0);
    check($sformatf("idle_done k%0d", k), 16'(done_w[k]), 16'd0);
  endtask

  // Follows one frame from the cycle after accept; returns on the done cycle.
  // seq collects the observed level at the start of each bit period.
  task automatic check_frame(input int k, input logic [8:0] data, input bit noise,
                             input bit abort, output logic [15:0] seq);
    logic q [$];
    logic par;
    int   w, t, nb, cnt, cyc;
    bit   finished, noise_done, noise_on;
    w = cw[k];  t = ct[k];
    cnt = 0;  cyc = 0;  finished = 0;  noise_done = 0;  noise_on = 0;
    seq = '0;
    par = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < w; i++) q.push_back((cl[k] == 1) ? data[i] : data[w-1-i]);
    for (int i = 0; i < w; i++) par = par ^ data[i];
    if (cp[k] == 1) q.push_back(par);
    if (cp[k] == 2) q.push_back(~par);
    for (int s = 0; s < cs[k]; s++) q.push_back(1'b1);
    nb = q.size();
    while (!finished && cyc < 20000) begin
      @(negedge clk);
      if (noise_on) begin
        start[k] = 1'b0;
        noise_on = 0;
      end
      if (cnt < nb * t) begin
        check($sformatf("line k%0d tick%0d", k, cnt), 16'(line_w[k]), 16'(q[cnt / t]));
        check($sformatf("busy k%0d tick%0d", k, cnt), 16'(busy_w[k]), 16'd1);
        check($sformatf("done k%0d tick%0d", k, cnt), 16'(done_w[k]), 16'd0);
        if ((cnt % t) == 0 && (cnt / t) < 16) seq[cnt / t] = line_w[k];
        if (noise && !noise_done && cnt == (nb * t) / 2) begin
          data_in[k] = 9'($urandom);
          start[k]   = 1'b1;
          noise_on   = 1;
          noise_done = 1;
        end
        if (abort && cnt == 4 * t + t / 2) begin
          rst_n = 1'b0;
          #1;
          check("abort_line", 16'(line_w[k]), 16'd1);
          check("abort_busy", 16'(busy_w[k]), 16'd0);
          check("abort_done", 16'(done_w[k]), 16'd0);
          repeat (2) begin
            @(negedge clk);
            check("abort_hold_line", 16'(line_w[k]), 16'd1);
            check("abort_hold_done", 16'(done_w[k]), 16'd0);
          end
          rst_n = 1'b1;
          return;
        end
      end else begin
        check($sformatf("end_line k%0d", k), 16'(line_w[k]), 16'd1);
        check($sformatf("end_busy k%0d", k), 16'(busy_w[k]), 16'd0);
        check($sformatf("end_done k%0d", k), 16'(done_w[k]), 16'd1);
        finished = 1;
      end
      if (!finished) begin
        @(posedge clk);
        if (rate) cnt++;
        cyc++;
      end
    end
    check($sformatf("frame_completed k%0d", k), 16'(finished), 16'd1);
  endtask

  initial begin
    logic [15:0] seq;
    logic [8:0]  d;
    int          k;
    rst_n      = 1'b0;
    rate_fixed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in[i] = '0;
      start[i]   = 1'b0;
    end

    // Reset state of every configuration
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_line k%0d", i), 16'(line_w[i]), 16'd1);
      check($sformatf("rst_busy k%0d", i), 16'(busy_w[i]), 16'd0);
      check($sformatf("rst_done k%0d", i), 16'(done_w[i]), 16'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 LSB-first, tick every 4 clocks, 0xA5
    send(0, 9'h0A5);
    check_frame(0, 9'h0A5, 0, 0, seq);
    check("t1_levels", seq & 16'h03FF, 16'h034A);
    idle_check(0);

    rate_fixed = 1'b0;

    // 8E2 and 8O2 with 0x07
    send(1, 9'h007);
    check_frame(1, 9'h007, 0, 0, seq);
    check("t2_even_levels", seq & 16'h0FFF, 16'h0E0E);
    idle_check(1);
    send(2, 9'h007);
    check_frame(2, 9'h007, 0, 0, seq);
    check("t2_odd_levels", seq & 16'h0FFF, 16'h0C0E);
    idle_check(2);

    // 7N1 MSB-first, 0x41
    send(3, 9'h041);
    check_frame(3, 9'h041, 0, 0, seq);
    check("t3_levels", seq & 16'h01FF, 16'h0182);
    idle_check(3);

    // Back-to-back: second request on the done cycle, no idle gap
    send(1, 9'h03C);
    check_frame(1, 9'h03C, 0, 0, seq);
    send(1, 9'h0C3);
    check_frame(1, 9'h0C3, 0, 0, seq);
    idle_check(1);

    // Data change and request pulse mid-frame are ignored
    d = 9'($urandom);
    send(2, d);
    check_frame(2, d, 1, 0, seq);
    idle_check(2);

    // Randomised frames across all configurations
    for (int n = 0; n < 8; n++) begin
      k = int'($urandom_range(0, 3));
      d = 9'($urandom);
      if (cw[k] < 9) d[8] = 1'b0;
      if (cw[k] < 8) d[7] = 1'b0;
      send(k, d);
      check_frame(k, d, ($urandom_range(0, 1) == 1), 0, seq);
      idle_check(k);
    end

    // Reset during data bit 3 aborts the frame; next request is a clean frame
    d = 9'($urandom) & 9'h0FF;
    send(0, d);
    check_frame(0, d, 0, 1, seq);
    idle_check(0);
    d = 9'h05A;
    send(0, d);
    check_frame(0, d, 0, 0, seq);
    check("post_abort_levels", seq & 16'h03FF, 16'h02B4);
    idle_check(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
